// File: rtl/clock_generation_pkg.sv
// clks_alot_p: shared types and sizing for the clock generation block
//   COUNTER_WIDTH        width of rate fields and the phase counter
//   generation_conf_s    {high_rate, low_rate, idle_level}
//   generated_events_s   {rising, falling, any}
//   gen_state_e          generator FSM states
package clks_alot_p;
   localparam int COUNTER_WIDTH = 8;
   typedef struct packed {
      logic [COUNTER_WIDTH-1:0] high_rate;
      logic [COUNTER_WIDTH-1:0] low_rate;
      logic                     idle_level;
   } generation_conf_s;
   typedef struct packed {
      logic rising;
      logic falling;
      logic any;
   } generated_events_s;
   typedef enum logic [1:0] {IDLE, HIGH, LOW} gen_state_e;
   // A zero rate would give a zero-length phase; run it as one cycle instead.
   function automatic logic [COUNTER_WIDTH-1:0] eff_rate(input logic [COUNTER_WIDTH-1:0] r);
      return r == '0 ? COUNTER_WIDTH'(1) : r;
   endfunction
endpackage

// File: rtl/clock_generation_phase_counter.sv
// phase_counter: shared HIGH/LOW phase counter, counts 1..terminal and stops there
//   clk, async_rst, clk_en   clock, async active-high reset, global enable
//   terminal                 last count of the current phase
//   load                     restart the count at 1
//   advance                  step the count toward terminal
//   reached                  count has reached terminal
module phase_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             async_rst,
   input  logic             clk_en,
   input  logic [WIDTH-1:0] terminal,
   input  logic             load,
   input  logic             advance,
   output logic             reached
);
   logic [WIDTH-1:0] count_q;
   assign reached = count_q >= terminal;
   always_ff @(posedge clk or posedge async_rst)
      if (async_rst) count_q <= WIDTH'(1);
      else if (clk_en) count_q <= load ? WIDTH'(1) : advance && !reached ? count_q + WIDTH'(1) : count_q;
endmodule

// File: rtl/clock_generation.sv
// clock_generation: programmable duty-cycle clock generator with period-aligned config updates
//   clk, async_rst         sole clock, async active-high reset
//   clk_en                 global enable, low freezes all state
//   generation_en_i        level request to run the generated clock
//   generation_config_i    {high_rate, low_rate, idle_level}
//   config_update_i        strobe capturing generation_config_i as pending
//   clk_o                  registered generated clock
//   generated_events_o     {rising, falling, any} pulses on clk_o edges
//   current_rate_o         active high_rate + low_rate, saturating
//   busy_o                 generator not idle
//   config_pending_o       captured config waiting for the next period boundary
module clock_generation
   import clks_alot_p::*;
#(
   parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH
) (
   input  logic                     clk,
   input  logic                     async_rst,
   input  logic                     clk_en,
   input  logic                     generation_en_i,
   input  generation_conf_s         generation_config_i,
   input  logic                     config_update_i,
   output logic                     clk_o,
   output generated_events_s        generated_events_o,
   output logic [COUNTER_WIDTH-1:0] current_rate_o,
   output logic                     busy_o,
   output logic                     config_pending_o
);
   gen_state_e state_q, state_d;
   generation_conf_s active_q, active_d, pending_q;
   generated_events_s events_q;
   logic [COUNTER_WIDTH-1:0] high_eff, low_eff, terminal;
   logic [COUNTER_WIDTH:0] rate_sum;
   logic reached, load, apply, clk_d;
   assign high_eff = COUNTER_WIDTH'(eff_rate(active_q.high_rate));
   assign low_eff = COUNTER_WIDTH'(eff_rate(active_q.low_rate));
   assign rate_sum = {1'b0, high_eff} + {1'b0, low_eff};
   assign current_rate_o = rate_sum[COUNTER_WIDTH] ? '1 : rate_sum[COUNTER_WIDTH-1:0];
   assign terminal = state_q == LOW ? low_eff : high_eff;
   assign busy_o = state_q != IDLE;
   assign generated_events_o = clk_en ? events_q : '0;
   phase_counter #(.WIDTH(COUNTER_WIDTH)) u_phase (
      .clk      (clk),
      .async_rst(async_rst),
      .clk_en   (clk_en),
      .terminal (terminal),
      .load     (load),
      .advance  (!load),
      .reached  (reached)
   );
   // Enable is only sampled at IDLE and at the end of LOW, so a dropped request never cuts a period short.
   always_comb begin
      state_d = state_q == IDLE ? (generation_en_i ? HIGH : IDLE) :
                !reached        ? state_q :
                state_q == HIGH ? LOW : (generation_en_i ? HIGH : IDLE);
      load = state_d != state_q || state_q == IDLE;
      apply = config_pending_o && state_d == HIGH && state_q != HIGH;
      active_d = apply ? pending_q : active_q;
      clk_d = state_d == HIGH ? 1'b1 : state_d == LOW ? 1'b0 : active_q.idle_level;
   end
   always_ff @(posedge clk or posedge async_rst)
      if (async_rst) begin
         state_q <= IDLE;
         active_q <= '0;
         pending_q <= '0;
         config_pending_o <= 1'b0;
         clk_o <= 1'b0;
         events_q <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         active_q <= active_d;
         pending_q <= config_update_i ? generation_config_i : pending_q;
         // A strobe landing on the applying edge stays pending for the next boundary.
         config_pending_o <= config_update_i || (config_pending_o && !apply);
         clk_o <= clk_d;
         events_q <= {clk_d & ~clk_o, ~clk_d & clk_o, clk_d ^ clk_o};
      end
endmodule

// File: tb/tb_clock_generation.sv
// tb_clock_generation: directed and randomized checks of clock_generation against a period-queue model
module tb_clock_generation;
   import clks_alot_p::*;
   logic clk = 1'b0;
   logic async_rst = 1'b1;
   logic clk_en = 1'b0;
   logic gen_en = 1'b0;
   logic cfg_upd = 1'b0;
   generation_conf_s gen_cfg = '0;
   logic clk_o, busy_o, config_pending_o;
   generated_events_s generated_events_o;
   logic [COUNTER_WIDTH-1:0] current_rate_o;
   int checks = 0;
   int errors = 0;
   bit m_q[$];
   logic m_lvl, m_busy, m_pend;
   int m_pos;
   generated_events_s m_ev;
   generation_conf_s m_act, m_pen;

   clock_generation dut (
      .clk                (clk),
      .async_rst          (async_rst),
      .clk_en             (clk_en),
      .generation_en_i    (gen_en),
      .generation_config_i(gen_cfg),
      .config_update_i    (cfg_upd),
      .clk_o              (clk_o),
      .generated_events_o (generated_events_o),
      .current_rate_o     (current_rate_o),
      .busy_o             (busy_o),
      .config_pending_o   (config_pending_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff(input int r);
      return r == 0 ? 1 : r;
   endfunction

   function automatic int m_rate();
      int s = eff(int'(m_act.high_rate)) + eff(int'(m_act.low_rate));
      return s > (1 << COUNTER_WIDTH) - 1 ? (1 << COUNTER_WIDTH) - 1 : s;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_lvl = 1'b0;
      m_busy = 1'b0;
      m_pend = 1'b0;
      m_pos = 0;
      m_ev = '0;
      m_act = '0;
      m_pen = '0;
   endtask

   // The model keeps the remaining levels of the current period in a queue; an empty queue is a boundary.
   task automatic model_edge(input logic en, input logic upd, input generation_conf_s cfg);
      logic nl;
      bit applied = 0;
      if (m_q.size() > 0) begin
         nl = m_q.pop_front();
         m_pos++;
      end else if (en) begin
         if (m_pend) begin
            m_act = m_pen;
            applied = 1;
         end
         for (int i = 0; i < eff(int'(m_act.high_rate)); i++) m_q.push_back(1'b1);
         for (int i = 0; i < eff(int'(m_act.low_rate)); i++) m_q.push_back(1'b0);
         nl = m_q.pop_front();
         m_pos = 0;
         m_busy = 1'b1;
      end else begin
         nl = m_act.idle_level;
         m_busy = 1'b0;
      end
      m_ev = {nl & ~m_lvl, ~nl & m_lvl, nl ^ m_lvl};
      m_lvl = nl;
      m_pend = upd | (m_pend & ~applied);
      if (upd) m_pen = cfg;
   endtask

   task automatic compare_all();
      check("clk_o", 32'(clk_o), 32'(m_lvl));
      check("events", 32'(generated_events_o), clk_en ? 32'(m_ev) : 32'(0));
      check("busy", 32'(busy_o), 32'(m_busy));
      check("pending", 32'(config_pending_o), 32'(m_pend));
      check("rate", 32'(current_rate_o), 32'(m_rate()));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_clk"}, 32'(clk_o), 0);
      check({tag, "_events"}, 32'(generated_events_o), 0);
      check({tag, "_busy"}, 32'(busy_o), 0);
      check({tag, "_pending"}, 32'(config_pending_o), 0);
      check({tag, "_rate"}, 32'(current_rate_o), 2);
   endtask

   task automatic step(input logic en, input logic upd, input logic ce, input generation_conf_s cfg);
      gen_en = en;
      cfg_upd = upd;
      clk_en = ce;
      gen_cfg = cfg;
      @(posedge clk);
      if (ce) model_edge(en, upd, cfg);
      #1;
      compare_all();
   endtask

   task automatic run_to(input int pos, input int hr);
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1'b1, 1'b0, 1'b1, '0);
         found = m_busy && m_pos == pos && int'(m_act.high_rate) == hr;
      end
      check("run_to_bound", 32'(found), 1);
   endtask

   function automatic generation_conf_s mk(input int h, input int l, input logic idl);
      generation_conf_s c;
      c.high_rate = COUNTER_WIDTH'(h);
      c.low_rate = COUNTER_WIDTH'(l);
      c.idle_level = idl;
      return c;
   endfunction

   initial begin
      logic pat [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      model_reset();
      #3;
      check_reset("por");
      #4;
      async_rst = 1'b0;
      step(1'b0, 1'b1, 1'b1, mk(3, 2, 1'b0));
      check("pend_set", 32'(config_pending_o), 1);
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 1'b0, 1'b1, '0);
         check("pattern_3_2", 32'(clk_o), 32'(pat[i % 5]));
      end
      check("rate_3_2", 32'(current_rate_o), 5);
      step(1'b1, 1'b1, 1'b1, mk(4, 4, 1'b1));
      run_to(1, 4);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, '0);
      check("drop_en_busy", 32'(busy_o), 0);
      check("drop_en_idle", 32'(clk_o), 1);
      step(1'b1, 1'b1, 1'b1, mk(2, 2, 1'b0));
      run_to(2, 2);
      step(1'b1, 1'b1, 1'b1, mk(1, 3, 1'b0));
      check("midlow_pend", 32'(config_pending_o), 1);
      run_to(0, 1);
      check("applied_pend", 32'(config_pending_o), 0);
      check("applied_rate", 32'(current_rate_o), 4);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 1'b1, mk(0, 0, 1'b0));
      run_to(0, 0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, '0);
      check("zero_rate", 32'(current_rate_o), 2);
      step(1'b1, 1'b1, 1'b1, mk(5, 5, 1'b0));
      run_to(1, 5);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
      check("frozen_clk", 32'(clk_o), 1);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 1'b1, mk(3, 4, 1'b1));
      run_to(4, 3);
      #3;
      async_rst = 1'b1;
      #1;
      check_reset("midlow_rst");
      model_reset();
      @(posedge clk);
      #2;
      check_reset("held_rst");
      async_rst = 1'b0;
      step(1'b1, 1'b0, 1'b1, '0);
      check("post_rst_high", 32'(clk_o), 1);
      for (int i = 0; i < 300; i++) begin
         int h = ($urandom_range(15) == 0) ? int'($urandom_range(255, 200)) : int'($urandom_range(6));
         int l = ($urandom_range(15) == 0) ? int'($urandom_range(255, 200)) : int'($urandom_range(6));
         step(logic'($urandom_range(4) != 0), logic'($urandom_range(7) == 0),
              logic'($urandom_range(7) != 0), mk(h, l, logic'($urandom_range(1))));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/clock_generation.md
CLOCK_GENERATION -- requirements
Module: clock_generation

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default clks_alot_p::COUNTER_WIDTH, width of all rate fields and the phase counter.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk  input  1  sole clock.
- async_rst  input  1  asynchronous, active-high reset.
- clk_en  input  1  global clock enable; low freezes all state.
- generation_en_i  input  1  level; request to run the generated clock.
- generation_config_i  input  clks_alot_p::generation_conf_s  {high_rate, low_rate, idle_level}.
- config_update_i  input  1  single-cycle strobe; capture generation_config_i as pending.
- clk_o  output  1  generated clock, registered.
- generated_events_o  output  clks_alot_p::generated_events_s  {rising, falling, any}, single-cycle pulses.
- current_rate_o  output  COUNTER_WIDTH  active (high_rate + low_rate) period in clk cycles.
- busy_o  output  1  high in any state except IDLE.
- config_pending_o  output  1  pending config not yet applied.

Function
REQ-003 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-004 IDLE: clk_o = active idle_level; phase counter held at 1.
- generation_en_i=1 -> HIGH next cycle.
- Pending config is applied on that transition.
REQ-005 HIGH: clk_o=1 for exactly high_rate enabled cycles.
- Counter counts 1..high_rate.
- At high_rate -> LOW, counter reset to 1.
REQ-006 LOW: clk_o=0 for exactly low_rate enabled cycles.
- At low_rate with generation_en_i=1 -> HIGH.
- At low_rate with generation_en_i=0 -> IDLE.
REQ-007 Deasserting generation_en_i mid-period SHALL NOT truncate the period; the current HIGH/LOW pair completes first.
REQ-008 A rate field of 0 SHALL be treated as 1; the minimum generated period is 2 cycles.
REQ-009 config_update_i SHALL load the pending register and set config_pending_o.
- A second strobe before application overwrites the pending config.
REQ-010 Pending config SHALL become active only on entry to HIGH (period boundary). config_pending_o clears that same cycle.
- config_update_i coincident with the applying cycle: the new value stays pending for the next boundary.
REQ-011 generated_events_o.rising SHALL pulse in the first cycle clk_o reads 1 after a 0; falling likewise for 1->0; any = rising | falling.
- IDLE->HIGH with idle_level=1 produces no rising pulse.
- LOW->IDLE with idle_level=1 produces a rising pulse.
REQ-012 current_rate_o SHALL equal active high_rate + low_rate (after the 0->1 substitution), saturating at all-ones. It updates on config application.
REQ-013 clk_en=0 SHALL hold all registers, including clk_o; event pulses read 0 while clk_en=0.
REQ-014 The phase counter SHALL never exceed the active rate. No wrap-around is permitted.

Reset
REQ-015 async_rst SHALL asynchronously force:
- state=IDLE, counter=1, clk_o=0.
- events=0, busy_o=0, config_pending_o=0.
- active and pending config = all-zero, so current_rate_o=2 (both zero rates substituted to 1).
REQ-016 Reset mid-period SHALL abort immediately. After release, generation restarts from IDLE with no partial phase.

Structure
REQ-017 clks_alot_p SHALL hold generation_conf_s, generated_events_s, and COUNTER_WIDTH. No new package is needed.
REQ-018 A sub-module phase_counter SHALL be instantiated, once for the shared HIGH/LOW counter:
- inputs: terminal value, load, advance.
- output: terminal-reached flag.

Verification
REQ-019 high=3, low=2, en held -> clk_o repeats 1,1,1,0,0. Rising every 5 cycles, current_rate_o=5.
REQ-020 high=4, low=4 running; drop en during HIGH cycle 2 -> 2 more HIGH cycles, 4 LOW cycles, then IDLE with clk_o=idle_level and busy_o=0.
REQ-021 high=2, low=2 running; update to high=1, low=3 mid-LOW -> old period completes. config_pending_o stays high until HIGH entry, then clk_o = 1,0,0,0 and current_rate_o=4.
REQ-022 high=0, low=0 -> clk_o toggles every cycle, current_rate_o=2.
REQ-023 Running at high=5, low=5; clk_en=0 for 3 cycles mid-HIGH -> clk_o frozen at 1, no events. The HIGH phase totals 5 enabled cycles.
REQ-024 Assert async_rst between clock edges mid-LOW -> outputs reach reset values before the next edge. After release with en=1, HIGH entry follows one cycle later.
